// File: rtl/store_lane_buffer_pkg.sv
// Shared store-path definitions: size codes and the buffered entry layout.
package store_lane_buffer_pkg;

  // Store size codes; 2'b11 is reserved and always treated as illegal.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Word address (30) + lane-replicated data (32) + byte enables (4).
  localparam int unsigned EntryWidth = 30 + 32 + 4;

  typedef struct packed {
    logic [29:0] wordAddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

endpackage

// File: rtl/store_lane_buffer_if.sv
// Store-side bus bundle: MEM-stage request channel, memory drain channel and status.
interface store_lane_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_addr;
  logic [31:0]              in_data;
  logic [1:0]               in_size;
  logic                     misalign;
  logic                     mem_req;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_be;
  logic                     mem_ack;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;

  // Buffer side.
  modport slave (
    input  in_valid, in_addr, in_data, in_size, mem_ack,
    output in_ready, misalign, mem_req, mem_addr, mem_wdata, mem_be, empty, count
  );

  // Pipeline/memory side.
  modport master (
    output in_valid, in_addr, in_data, in_size, mem_ack,
    input  in_ready, misalign, mem_req, mem_addr, mem_wdata, mem_be, empty, count
  );
endinterface

// File: rtl/store_lane_buffer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is visible without a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AddrW:0]   wrPtr;
  logic [AddrW:0]   rdPtr;
  logic             doPush;
  logic             doPop;

  // Guard against overflow/underflow regardless of caller behaviour.
  always_comb begin
    doPush = push && !full;
    doPop  = pop && !empty;
  end

  // Storage and pointer update; entries cleared on reset so head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        storage[i] <= '0;
      end
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) begin
        storage[wrPtr[AddrW-1:0]] <= pushData;
        wrPtr <= wrPtr + (AddrW + 1)'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + (AddrW + 1)'(1);
      end
    end
  end

  // Status purely from registered pointers: same index, wrap bit tells full from empty.
  always_comb begin
    empty    = (wrPtr == rdPtr);
    full     = (wrPtr[AddrW-1:0] == rdPtr[AddrW-1:0]) && (wrPtr[AddrW] != rdPtr[AddrW]);
    count    = wrPtr - rdPtr;
    headData = storage[rdPtr[AddrW-1:0]];
  end
endmodule

// File: rtl/store_lane_buffer.sv
// Narrows register data into byte-lane stores and queues them in order toward data memory.
module store_lane_buffer
  import store_lane_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  store_lane_buffer_if.slave bus
);
  logic [31:0]            laneData;
  logic [3:0]             laneBe;
  logic                   illegal;
  logic                   accept;
  logic                   doPush;
  logic                   doPop;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [$clog2(DEPTH):0] fifoCount;
  entry_t                 pushEntry;
  logic [EntryWidth-1:0]  headBits;
  entry_t                 headEntry;
  logic                   misalignQ;

  // Size decode: lane replication, byte enables and alignment check.
  always_comb begin
    laneData = '0;
    laneBe   = '0;
    illegal  = 1'b0;
    case (bus.in_size)
      SZ_B: begin
        laneData = {4{bus.in_data[7:0]}};
        laneBe   = 4'b0001 << bus.in_addr[1:0];
      end
      SZ_H: begin
        laneData = {2{bus.in_data[15:0]}};
        laneBe   = bus.in_addr[1] ? 4'b1100 : 4'b0011;
        illegal  = bus.in_addr[0];
      end
      SZ_W: begin
        laneData = bus.in_data;
        laneBe   = 4'b1111;
        illegal  = (bus.in_addr[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Handshake qualification; illegal stores are consumed but never enqueued.
  always_comb begin
    accept             = bus.in_valid && !fifoFull;
    doPush             = accept && !illegal;
    doPop              = !fifoEmpty && bus.mem_ack;
    pushEntry.wordAddr = bus.in_addr[31:2];
    pushEntry.wdata    = laneData;
    pushEntry.be       = laneBe;
    headEntry          = entry_t'(headBits);
  end

  sync_fifo #(
    .WIDTH (EntryWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (doPush),
    .pushData (pushEntry),
    .pop      (doPop),
    .headData (headBits),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // One-cycle misalign pulse following an accepted illegal store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalignQ <= 1'b0;
    end else begin
      misalignQ <= accept && illegal;
    end
  end

  // Outputs derive only from registered state (no mem_ack -> in_ready path).
  always_comb begin
    bus.in_ready  = !fifoFull;
    bus.misalign  = misalignQ;
    bus.mem_req   = !fifoEmpty;
    bus.mem_addr  = {headEntry.wordAddr, 2'b00};
    bus.mem_wdata = headEntry.wdata;
    bus.mem_be    = headEntry.be;
    bus.empty     = fifoEmpty;
    bus.count     = fifoCount;
  end
endmodule

// File: tb/tb_store_lane_buffer.sv
// Directed bench for store_lane_buffer with a queue-based reference model.
module tb_store_lane_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  store_lane_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_lane_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  logic expMis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A store is legal when its size is defined and its address is a multiple of its byte count.
  function automatic bit legalOf(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    if (size == 2'b11) return 1'b0;
    nb = 1 << size;
    return (addr % nb) == 0;
  endfunction

  // Byte lane i carries source byte (i mod size); enables cover size bytes from addr offset.
  function automatic exp_t entryOf(input logic [1:0] size, input logic [31:0] addr,
                                   input logic [31:0] data);
    exp_t e;
    int nb;
    nb = 1 << size;
    e.addr = addr & 32'hFFFF_FFFC;
    e.be   = 4'(((1 << nb) - 1) << addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      e.wdata[8*i +: 8] = data[8*(i % nb) +: 8];
    end
    return e;
  endfunction

  // Reference model, updated on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      expMis <= 1'b0;
    end else begin
      expMis <= bus.in_valid && (q.size() < DEPTH) && !legalOf(bus.in_size, bus.in_addr);
      if (bus.mem_ack && q.size() != 0) begin
        if (bus.in_valid && q.size() < DEPTH && legalOf(bus.in_size, bus.in_addr))
          q.push_back(entryOf(bus.in_size, bus.in_addr, bus.in_data));
        void'(q.pop_front());
      end else if (bus.in_valid && q.size() < DEPTH && legalOf(bus.in_size, bus.in_addr)) begin
        q.push_back(entryOf(bus.in_size, bus.in_addr, bus.in_data));
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("count", 32'(bus.count), 32'(q.size()));
    check("mem_req", 32'(bus.mem_req), 32'(q.size() != 0));
    check("misalign", 32'(bus.misalign), 32'(expMis));
    if (q.size() != 0) begin
      check("mem_addr", bus.mem_addr, q[0].addr);
      check("mem_wdata", bus.mem_wdata, q[0].wdata);
      check("mem_be", 32'(bus.mem_be), 32'(q[0].be));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic v, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    bus.in_valid = v;
    bus.in_size  = sz;
    bus.in_addr  = a;
    bus.in_data  = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    setIn(1'b0, 2'b00, 32'h0, 32'h0);
    bus.mem_ack = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_be", 32'(bus.mem_be), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // SB to the top lane.
    setIn(1'b1, 2'b00, 32'h0000_1003, 32'hAABB_CCDD);
    step();
    setIn(1'b0, 2'b00, 32'h0, 32'h0);
    check("sb_req", 32'(bus.mem_req), 32'd1);
    check("sb_addr", bus.mem_addr, 32'h0000_1000);
    check("sb_be", 32'(bus.mem_be), 32'h8);
    check("sb_wdata", bus.mem_wdata, 32'hDDDD_DDDD);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("sb_drained", 32'(bus.empty), 32'd1);

    // SH upper half, then misaligned SH.
    setIn(1'b1, 2'b01, 32'h0000_2002, 32'h1234_5678);
    step();
    check("sh_be", 32'(bus.mem_be), 32'hC);
    check("sh_wdata", bus.mem_wdata, 32'h5678_5678);
    bus.mem_ack = 1'b1;
    setIn(1'b1, 2'b01, 32'h0000_2001, 32'h1234_5678);
    step();
    bus.mem_ack = 1'b0;
    setIn(1'b0, 2'b00, 32'h0, 32'h0);
    check("sh_mis_pulse", 32'(bus.misalign), 32'd1);
    check("sh_mis_count", 32'(bus.count), 32'd0);
    step();
    check("sh_mis_gone", 32'(bus.misalign), 32'd0);

    // Fill with SW, stall the fifth, free one slot.
    for (int i = 0; i < 4; i++) begin
      setIn(1'b1, 2'b10, 32'h0000_4000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      step();
    end
    check("full_count", 32'(bus.count), 32'd4);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    setIn(1'b1, 2'b10, 32'h0000_4010, 32'hC0DE_0004);
    repeat (2) step();
    check("stall_count", 32'(bus.count), 32'd4);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("ready_back", 32'(bus.in_ready), 32'd1);
    check("pop_order", bus.mem_addr, 32'h0000_4004);
    step();
    setIn(1'b0, 2'b00, 32'h0, 32'h0);
    check("fifth_in", 32'(bus.count), 32'd4);
    bus.mem_ack = 1'b1;
    repeat (4) step();
    bus.mem_ack = 1'b0;
    check("fill_drained", 32'(bus.empty), 32'd1);

    // Sustained push and pop.
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      setIn(1'b1, 2'b10, 32'h0000_5000 + 32'(4 * i), 32'h5000_0000 + 32'(i));
      step();
      if (i == 10) check("stream_count", 32'(bus.count), 32'd1);
    end
    setIn(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    bus.mem_ack = 1'b0;
    check("stream_empty", 32'(bus.empty), 32'd1);

    // Reset mid-operation with entries queued and a misalign pulse pending.
    for (int i = 0; i < 3; i++) begin
      setIn(1'b1, 2'b00, 32'h0000_6000 + 32'(i), 32'h0000_00A0 + 32'(i));
      step();
    end
    setIn(1'b1, 2'b10, 32'h0000_6001, 32'h0);
    step();
    setIn(1'b0, 2'b00, 32'h0, 32'h0);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    check("pre_rst_mis", 32'(bus.misalign), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(bus.mem_req), 32'd0);
    check("async_mis", 32'(bus.misalign), 32'd0);
    check("async_count", 32'(bus.count), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("post_rst_empty", 32'(bus.empty), 32'd1);
    check("post_rst_req", 32'(bus.mem_req), 32'd0);

    // Reserved size and misaligned SW; then mem_ack while idle.
    setIn(1'b1, 2'b11, 32'h0000_3000, 32'hFFFF_FFFF);
    step();
    check("sz11_mis", 32'(bus.misalign), 32'd1);
    setIn(1'b1, 2'b10, 32'h0000_3002, 32'hFFFF_FFFF);
    step();
    setIn(1'b0, 2'b00, 32'h0, 32'h0);
    check("sw_mis", 32'(bus.misalign), 32'd1);
    check("sw_mis_req", 32'(bus.mem_req), 32'd0);
    bus.mem_ack = 1'b1;
    repeat (3) step();
    bus.mem_ack = 1'b0;
    check("idle_ack_count", 32'(bus.count), 32'd0);
    check("idle_ack_mis", 32'(bus.misalign), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
